// File: rtl/test_exit_pkg.sv
// Shared definitions for the test-exit controller: state encoding, register map,
// STATUS layout and the byte-lane merge used by writable registers.
package test_exit_pkg;

  // Encoding chosen so STATUS[4:3] reads 01 once the test has completed normally.
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DONE    = 2'b01,
    ST_DRAIN   = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  localparam int unsigned ExitCodeWidth = 31;

  localparam logic [7:0] OFF_TOHOST   = 8'h00;
  localparam logic [7:0] OFF_CHAR_OUT = 8'h04;
  localparam logic [7:0] OFF_CYCLE_LO = 8'h08;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h0C;
  localparam logic [7:0] OFF_TIMEOUT  = 8'h10;
  localparam logic [7:0] OFF_STATUS   = 8'h14;

  localparam int unsigned STAT_DONE      = 0;
  localparam int unsigned STAT_PASS      = 1;
  localparam int unsigned STAT_TIMEOUT   = 2;
  localparam int unsigned STAT_STATE_LSB = 3;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/test_exit_cnt64.sv
// 64-bit free-running cycle counter with a high-word shadow, latched on a low-word
// read so that a LO-then-HI read pair is coherent.
module test_exit_cnt64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        latch_hi_i,
  output logic [63:0] cnt_o,
  output logic [31:0] hi_shadow_o
);

  logic [63:0] cnt_q;
  logic [31:0] hi_shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      hi_shadow_q <= '0;
    end else begin
      if (en_i)       cnt_q       <= cnt_q + 64'd1;
      if (latch_hi_i) hi_shadow_q <= cnt_q[63:32];
    end
  end

  assign cnt_o       = cnt_q;
  assign hi_shadow_o = hi_shadow_q;

endmodule

// File: rtl/test_exit_ctrl.sv
// Memory-mapped end-of-test controller: tohost capture with drain delay, console
// strobe, coherent 64-bit cycle counter and a watchdog, behind a 1-cycle bus response.
module test_exit_ctrl
  import test_exit_pkg::*;
#(
  parameter int unsigned AddrWidth    = 8,
  parameter int unsigned DrainCycles  = 4,
  parameter logic [31:0] TimeoutReset = 32'd1000000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [AddrWidth-1:0]     addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     err_o,
  output logic                     char_valid_o,
  output logic [7:0]               char_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     timeout_o,
  output logic [ExitCodeWidth-1:0] exit_code_o,
  output logic [63:0]              cycle_o
);

  state_e                   state_q, state_d;
  logic [7:0]               drain_q, drain_d;
  logic [31:0]              tohost_q, tohost_d, timeout_q, timeout_d;
  logic [ExitCodeWidth-1:0] exit_q, exit_d;
  logic                     rvalid_q, err_q, err_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     char_valid_q, char_valid_d;
  logic [7:0]               char_q, char_d;

  logic                 rd, wr, running, terminal;
  logic                 tohost_we, timeout_we, latch_hi;
  logic [AddrWidth-1:0] off;
  logic [63:0]          cycle;
  logic [31:0]          hi_shadow, tohost_merged, status;
  logic                 unused_addr;

  assign rd          = req_i & ~we_i;
  assign wr          = req_i & we_i;
  assign off         = {addr_i[AddrWidth-1:2], 2'b00};
  assign unused_addr = ^addr_i[1:0];
  assign running     = (state_q == ST_RUN);
  assign terminal    = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);

  assign tohost_merged = be_merge(tohost_q, wdata_i, be_i);

  test_exit_cnt64 u_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (state_q != ST_DONE),
    .latch_hi_i  (latch_hi),
    .cnt_o       (cycle),
    .hi_shadow_o (hi_shadow)
  );

  always_comb begin
    status = '0;
    status[STAT_DONE]              = done_o;
    status[STAT_PASS]              = pass_o;
    status[STAT_TIMEOUT]           = timeout_o;
    status[STAT_STATE_LSB +: 2]    = state_q;
  end

  // Bus decode: read data, error response and per-register write strobes.
  always_comb begin
    rdata_d      = '0;
    err_d        = 1'b0;
    tohost_we    = 1'b0;
    timeout_we   = 1'b0;
    latch_hi     = 1'b0;
    char_valid_d = 1'b0;
    case (off)
      AddrWidth'(OFF_TOHOST): begin
        if (rd) rdata_d = tohost_q;
        tohost_we = wr & running;
      end
      AddrWidth'(OFF_CHAR_OUT): char_valid_d = wr & be_i[0] & ~terminal;
      AddrWidth'(OFF_CYCLE_LO): begin
        if (rd) rdata_d = cycle[31:0];
        latch_hi = rd;
        err_d    = wr;
      end
      AddrWidth'(OFF_CYCLE_HI): begin
        if (rd) rdata_d = hi_shadow;
        err_d = wr;
      end
      AddrWidth'(OFF_TIMEOUT): begin
        if (rd) rdata_d = timeout_q;
        timeout_we = wr & ~terminal;
      end
      AddrWidth'(OFF_STATUS): begin
        if (rd) rdata_d = status;
        err_d = wr;
      end
      default: err_d = req_i;
    endcase
  end

  assign char_d    = char_valid_d ? wdata_i[7:0] : char_q;
  assign timeout_d = timeout_we ? be_merge(timeout_q, wdata_i, be_i) : timeout_q;

  // An exit write is checked before the watchdog so it wins a same-cycle tie.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    exit_d   = exit_q;
    tohost_d = tohost_we ? tohost_merged : tohost_q;
    case (state_q)
      ST_RUN: begin
        if (tohost_we && tohost_merged[0]) begin
          state_d = ST_DRAIN;
          exit_d  = tohost_merged[31:1];
          drain_d = 8'(DrainCycles);
        end else if ((timeout_q != '0) && (cycle[31:0] >= timeout_q)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 8'd1;
        if (drain_q <= 8'd1) state_d = ST_DONE;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      drain_q      <= '0;
      tohost_q     <= '0;
      timeout_q    <= TimeoutReset;
      exit_q       <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_q       <= '0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      tohost_q     <= tohost_d;
      timeout_q    <= timeout_d;
      exit_q       <= exit_d;
      rvalid_q     <= req_i;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      char_valid_q <= char_valid_d;
      char_q       <= char_d;
    end
  end

  assign rvalid_o     = rvalid_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign char_valid_o = char_valid_q;
  assign char_o       = char_q;
  assign done_o       = terminal;
  assign pass_o       = (state_q == ST_DONE) && (exit_q == '0);
  assign timeout_o    = (state_q == ST_TIMEOUT);
  assign exit_code_o  = exit_q;
  assign cycle_o      = cycle;

endmodule

// File: doc/test_exit_ctrl.md
Name: test_exit_ctrl

Overview:
Memory-mapped simulation/host-control peripheral on the core's data bus. It sits downstream of the core inside ibex_top_myself and consumes the core's stores to decide the end of a test.
- Captures riscv-tests style tohost writes and drives pass/fail/done and exit-code outputs to the bench.
- Streams console characters.
- Exposes a 64-bit cycle counter.
- Enforces a watchdog timeout.

Parameters:
AddrWidth, 8, number of byte-offset address bits decoded (device base already stripped by the bus).
DrainCycles, 4, cycles held in DRAIN between tohost capture and done_o assertion (1..255).
TimeoutReset, 32'd1000000, reset value of TIMEOUT register; 0 disables the watchdog.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  device request (grant implicit, always accepted)
we_i  in  1  1 = write
be_i  in  4  byte enables
addr_i  in  AddrWidth  byte offset
wdata_i  in  32  write data
rvalid_o  out  1  response valid, exactly one cycle after each req_i
rdata_o  out  32  read data (0 on writes and errors)
err_o  out  1  error response, qualified by rvalid_o
char_valid_o  out  1  one-cycle console strobe
char_o  out  8  console byte
done_o  out  1  test finished (sticky)
pass_o  out  1  finished with exit code 0
timeout_o  out  1  watchdog fired (sticky)
exit_code_o  out  31  tohost[31:1] as captured
cycle_o  out  64  free-running cycle count

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low. rst_ni low clears every flop at once, also mid-test.
- Reset values: all outputs 0; TIMEOUT = TimeoutReset; state = RUN.
- Register map (word aligned; addr_i[1:0] ignored):
  - 0x00 TOHOST: W/R.
  - 0x04 CHAR_OUT: W; reads 0.
  - 0x08 CYCLE_LO: R.
  - 0x0C CYCLE_HI: R.
  - 0x10 TIMEOUT: W/R.
  - 0x14 STATUS: R; {27'b0, state[1:0], timeout, pass, done}.
- Unmapped offset: rvalid_o = 1, err_o = 1, no side effect. Writes to read-only registers give err_o = 1.
- Response: registered. rvalid_o = req_i delayed one cycle; rdata_o/err_o are valid in that same cycle. Back-to-back requests are supported every cycle.
- Byte enables:
  - TOHOST and TIMEOUT writes merge per byte lane.
  - CHAR_OUT fires only if be_i[0]; char_o = wdata_i[7:0]; char_valid_o is high in the cycle after the accepted request.
- Cycle counter:
  - 64-bit; +1 every cycle while state != DONE; frozen in DONE; wraps to 0 modulo 2^64.
  - A CYCLE_LO read latches the high word into a shadow register. A CYCLE_HI read returns the shadow, giving a coherent 64-bit read.
  - cycle_o shows the live value.
- State machine:
  - RUN → DRAIN: accepted TOHOST write whose merged value has bit0 = 1. Capture exit_code = value[31:1] and load the drain counter with DrainCycles.
  - RUN, TOHOST write with bit0 = 0: the register is stored, no transition.
  - RUN → TIMEOUT: TIMEOUT != 0 and cycle[31:0] >= TIMEOUT. Sets timeout_o, done_o = 1, pass_o = 0.
  - DRAIN: decrement each cycle; when the counter hits 0 → DONE. Further TOHOST writes in DRAIN are ignored (rvalid, no err).
  - DONE: done_o = 1; pass_o = (exit_code == 0). Sticky until reset; all writes ignored, reads served.
  - TIMEOUT: terminal, sticky until reset.
- Simultaneous events: a TOHOST exit write and watchdog expiry in the same cycle → the TOHOST write wins (DRAIN). The watchdog is evaluated only in RUN.
- char_valid_o may still pulse in DRAIN; it is suppressed in DONE and TIMEOUT.

Decomposition:
- Package test_exit_pkg holds:
  - state enum (RUN, DRAIN, DONE, TIMEOUT);
  - register offset localparams;
  - STATUS bit positions;
  - the exit-code width constant.
- One natural sub-module, test_exit_cnt64: 64-bit counter with enable and hi-word shadow latch.
- The bus decode and FSM stay in the top module.

Test Plan:
- Reset mid-RUN (cycle ≈ 500), rst_ni low 3 cycles → all outputs 0, TIMEOUT reads 0x000F4240, counter restarts at 0.
- Write TOHOST = 0x00000001 → DrainCycles = 4 cycles later done_o = 1, pass_o = 1, exit_code_o = 0, STATUS reads 0x0B, cycle_o frozen.
- Write TOHOST = 0x0000002B → done_o = 1, pass_o = 0, exit_code_o = 0x15; a later TOHOST = 1 write does not change the result.
- TIMEOUT = 100 with no TOHOST write → at cycle[31:0] = 100, timeout_o = done_o = 1, pass_o = 0.
- TOHOST exit write in the same cycle the watchdog expires → timeout_o = 0, ends in DONE.
- CHAR_OUT writes 0x48 (be = 0001) then 0x69 (be = 0010) → one strobe with char_o = 0x48 only.
- Read offset 0x20 → rvalid_o = 1, err_o = 1, rdata_o = 0.
- Force the counter to 0x00000000_FFFFFFFF, then read LO then HI → returns 0xFFFFFFFF / 0x00000000 consistently.
